jt51_pg_mslot: RTL

// - Time-multiplexed phase generator for SLOTS operator slots. One slot is processed per clk_en.
// - Pipeline stages: octave shift of the ROM increment, LIMIT clamp, DT1 offset (saturating),
//   MUL scaling, then per-slot phase accumulation.
// - Sits between the phinc ROM / DT1 logic and the operator sine lookup.
// - Generalises the fixed 32-slot, 20-bit generator: slot count, widths and clamp are parameters.
// - Keeps an internal slot counter and per-slot phase storage.

---
 rtl/jt51_pg_mslot.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/jt51_pg_mslot.sv
// Time-multiplexed phase generator: octave shift, clamp, DT1, MUL, then per-slot accumulate.
// Optional phase modulation input enabled by defining JT51_PG_PHMOD_EN.
module jt51_pg_mslot #(
  parameter int          SLOTS = 32,
  parameter int          PHW   = 20,
  parameter int          OUTW  = 10,
  parameter int unsigned LIMIT = 82976,
  localparam int         SW    = $clog2(SLOTS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic [11:0]     phinc_I,
  input  logic [3:0]      oct_I,
  input  logic [4:0]      dt1_off_I,
  input  logic            dt1_neg_I,
  input  logic [3:0]      mul_I,
  input  logic            keyon_I,
`ifdef JT51_PG_PHMOD_EN
  input  logic [OUTW-1:0] pmod_I,
`endif
  output logic [SW-1:0]   slot_I,
  output logic            zero,
  output logic [OUTW-1:0] phase_out,
  output logic [SW-1:0]   out_slot,
  output logic            out_vld
);

  localparam logic [17:0] LIM = 18'(LIMIT);
  localparam int          MW  = (PHW > 23) ? PHW : 23;

  logic [SW-1:0]   slot_q, slot_d;
  logic [3:0]      vld_pipe_q;

  logic [17:0]     s1_base_q, s1_base_d;
  logic [4:0]      s1_off_q;
  logic            s1_neg_q, s1_key_q;
  logic [3:0]      s1_mul_q;
  logic [SW-1:0]   s1_slot_q;

  logic [18:0]     s2_val_q, s2_val_d;
  logic [3:0]      s2_mul_q;
  logic            s2_key_q;
  logic [SW-1:0]   s2_slot_q;

  logic [PHW-1:0]  s3_step_q, s3_step_d;
  logic            s3_key_q;
  logic [SW-1:0]   s3_slot_q;

  logic [PHW-1:0]  acc_q [SLOTS];
  logic [PHW-1:0]  acc_new;
  logic [OUTW-1:0] phase_q, phase_d;
  logic [SW-1:0]   out_slot_q;

  logic [17:0]     ext, base_c;
  logic [MW-1:0]   prod;

`ifdef JT51_PG_PHMOD_EN
  logic [OUTW-1:0] s1_pm_q, s2_pm_q, s3_pm_q;
`endif

  always_comb begin
    slot_d    = (slot_q == SW'(SLOTS-1)) ? '0 : slot_q + 1'b1;
    ext       = {phinc_I, 6'b0};
    s1_base_d = (oct_I > 4'd8) ? '0 : ext >> (4'd8 - oct_I);
    base_c    = (s1_base_q > LIM) ? LIM : s1_base_q;
    // Subtraction saturates at zero; addition has a spare bit so it never wraps.
    if (s1_neg_q)
      s2_val_d = (base_c < 18'(s1_off_q)) ? '0 : {1'b0, base_c - 18'(s1_off_q)};
    else
      s2_val_d = {1'b0, base_c} + 19'(s1_off_q);
    prod      = (s2_mul_q == 4'd0) ? MW'(s2_val_q >> 1) : MW'(s2_val_q) * MW'(s2_mul_q);
    s3_step_d = prod[PHW-1:0];
    acc_new   = s3_key_q ? '0 : acc_q[s3_slot_q] + s3_step_q;
`ifdef JT51_PG_PHMOD_EN
    phase_d   = acc_new[PHW-1 -: OUTW] + s3_pm_q;
`else
    phase_d   = acc_new[PHW-1 -: OUTW];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q     <= '0;
      vld_pipe_q <= '0;
      s1_base_q  <= '0;
      s1_off_q   <= '0;
      s1_neg_q   <= 1'b0;
      s1_key_q   <= 1'b0;
      s1_mul_q   <= '0;
      s1_slot_q  <= '0;
      s2_val_q   <= '0;
      s2_mul_q   <= '0;
      s2_key_q   <= 1'b0;
      s2_slot_q  <= '0;
      s3_step_q  <= '0;
      s3_key_q   <= 1'b0;
      s3_slot_q  <= '0;
      phase_q    <= '0;
      out_slot_q <= '0;
      for (int i = 0; i < SLOTS; i++) acc_q[i] <= '0;
`ifdef JT51_PG_PHMOD_EN
      s1_pm_q    <= '0;
      s2_pm_q    <= '0;
      s3_pm_q    <= '0;
`endif
    end else if (clk_en) begin
      slot_q     <= slot_d;
      vld_pipe_q <= {vld_pipe_q[2:0], 1'b1};
      s1_base_q  <= s1_base_d;
      s1_off_q   <= dt1_off_I;
      s1_neg_q   <= dt1_neg_I;
      s1_key_q   <= keyon_I;
      s1_mul_q   <= mul_I;
      s1_slot_q  <= slot_q;
      s2_val_q   <= s2_val_d;
      s2_mul_q   <= s1_mul_q;
      s2_key_q   <= s1_key_q;
      s2_slot_q  <= s1_slot_q;
      s3_step_q  <= s3_step_d;
      s3_key_q   <= s2_key_q;
      s3_slot_q  <= s2_slot_q;
`ifdef JT51_PG_PHMOD_EN
      s1_pm_q    <= pmod_I;
      s2_pm_q    <= s1_pm_q;
      s3_pm_q    <= s2_pm_q;
`endif
      // Stage IV only commits once real slot data has reached it.
      if (vld_pipe_q[2]) begin
        acc_q[s3_slot_q] <= acc_new;
        phase_q          <= phase_d;
        out_slot_q       <= s3_slot_q;
      end
    end
  end

  assign slot_I    = slot_q;
  assign zero      = (slot_q == '0);
  assign phase_out = phase_q;
  assign out_slot  = out_slot_q;
  assign out_vld   = vld_pipe_q[3];

endmodule
